// File: rtl/buf_pkg.sv
// Shared types and helpers for the burst buffer reader: FSM state encoding,
// buffer depth derivation and burst-length clamping.
package buf_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_e;

    localparam int unsigned MIN_BURST = 1;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    // A zero length still moves one sample; anything past the buffer depth could never start.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
        if (len < MIN_BURST) return MIN_BURST;
        if (len > depth) return depth;
        return len;
    endfunction

endpackage

// File: rtl/buf_oreg.sv
// Registered output stage with valid/ready handshake; holds the word and its
// burst markers until the consumer takes it.
module buf_oreg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              sop_i,
    input  logic              eop_i,
    input  logic              ready_i,
    output logic              can_load_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              sop_o,
    output logic              eop_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;

    assign can_load_o = !valid_q || ready_i;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        if (flush_i) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
        end else if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
            sop_d   = sop_i;
            eop_d   = eop_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign sop_o   = sop_q;
    assign eop_o   = eop_q;

endmodule

// File: rtl/buf_reader.sv
// Circular-buffer controller over an external dual-port RAM: gates writes,
// tracks fill/overflow and drains fixed-length bursts through buf_oreg.
module buf_reader
    import buf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              flush,
    input  logic [ADDR_W:0]   blk_len,
    input  logic              ovf_clr,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [ADDR_W:0]   fill,
    output logic              ovf
);

    localparam int unsigned DEPTH    = depth_of(ADDR_W);
    localparam int          LW       = ADDR_W + 1;
    localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [LW-1:0]     fill_q, fill_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic          full;
    logic [LW-1:0] len_req;
    logic          can_load;
    logic          rd_fire;
    logic          rd_sop;
    logic          rd_eop;

    assign full    = (fill_q == FULL_CNT);
    assign ram_we  = wr_en && !full && !flush;
    assign len_req = LW'(clamp_len(32'(blk_len), DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (fill_q >= len_req) state_d = ST_BURST;
                ST_BURST: if (rd_fire && rd_eop) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // A burst only starts once L samples are stored, so fill_q != 0 is a guard, not flow control.
    always_comb begin
        rd_fire = 1'b0;
        if (state_q == ST_BURST && !flush && fill_q != '0) rd_fire = can_load;
        rd_sop = (cnt_q == '0);
        rd_eop = (cnt_q == len_q - LW'(1));
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        ovf_d  = (wr_en && full) || (ovf_q && !ovf_clr);
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else begin
            if (ram_we) wptr_d = wptr_q + ADDR_W'(1);
            if (rd_fire) begin
                rptr_d = rptr_q + ADDR_W'(1);
                cnt_d  = rd_eop ? '0 : cnt_q + LW'(1);
            end
            case ({ram_we, rd_fire})
                2'b10:   fill_d = fill_q + LW'(1);
                2'b01:   fill_d = fill_q - LW'(1);
                default: fill_d = fill_q;
            endcase
            if (state_q == ST_IDLE && state_d == ST_BURST) len_d = len_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            len_q  <= LW'(MIN_BURST);
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            ovf_q  <= ovf_d;
        end
    end

    buf_oreg #(
        .DATA_W(DATA_W)
    ) u_oreg (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush),
        .load_i    (rd_fire),
        .data_i    (ram_rdata),
        .sop_i     (rd_sop),
        .eop_i     (rd_eop),
        .ready_i   (out_ready),
        .can_load_o(can_load),
        .data_o    (out_data),
        .valid_o   (out_valid),
        .sop_o     (out_sop),
        .eop_o     (out_eop)
    );

    assign ram_waddr = wptr_q;
    assign ram_raddr = rptr_q;
    assign fill      = fill_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_buf_reader.sv
// Directed bench for buf_reader at ADDR_W=4 with a behavioural dual-port RAM
// and a negedge collector of accepted output words.
module tb_buf_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        flush = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  blk_len = 5'd4;
    logic [31:0] wdata = '0;
    logic        ram_we;
    logic [3:0]  ram_waddr;
    logic [3:0]  ram_raddr;
    logic [31:0] ram_rdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic [4:0]  fill;
    logic        ovf;

    logic [31:0] mem [16];
    logic [31:0] rec_data [$];
    logic        rec_sop [$];
    logic        rec_eop [$];

    int checks = 0;
    int failures = 0;

    logic [31:0] held_data;
    logic        held_sop;
    logic        held_eop;
    logic        hold_pend;
    logic        found;

    buf_reader #(
        .DATA_W(32),
        .ADDR_W(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .flush    (flush),
        .blk_len  (blk_len),
        .ovf_clr  (ovf_clr),
        .ram_we   (ram_we),
        .ram_waddr(ram_waddr),
        .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .fill     (fill),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) mem[ram_waddr] <= wdata;
    assign ram_rdata = mem[ram_raddr];

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            rec_data.push_back(out_data);
            rec_sop.push_back(out_sop);
            rec_eop.push_back(out_eop);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] d);
        wr_en = wr;
        wdata = d;
        tick();
    endtask

    task automatic doFlush();
        wr_en = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic clearRec();
        rec_data.delete();
        rec_sop.delete();
        rec_eop.delete();
    endtask

    task automatic checkBursts(input string tag, input int n, input int len, input logic [31:0] base);
        checkOutput({tag, "_count"}, 32'(rec_data.size()), 32'(n));
        for (int i = 0; i < rec_data.size() && i < n; i++) begin
            checkOutput({tag, "_data"}, rec_data[i], base + 32'(i));
            checkOutput({tag, "_sop"}, 32'(rec_sop[i]), 32'((i % len) == 0));
            checkOutput({tag, "_eop"}, 32'(rec_eop[i]), 32'((i % len) == len - 1));
        end
    endtask

    initial begin
        $display("[TB] start");
        #12;
        checkOutput("rst_fill", 32'(fill), 0);
        checkOutput("rst_valid", 32'(out_valid), 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_ovf", 32'(ovf), 0);
        checkOutput("rst_waddr", 32'(ram_waddr), 0);
        checkOutput("rst_raddr", 32'(ram_raddr), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Two back-to-back bursts of four
        $display("[TB] two bursts");
        blk_len = 5'd4;
        out_ready = 1'b1;
        clearRec();
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 32'(i));
        wr_en = 1'b0;
        repeat (12) tick();
        checkBursts("burst8", 8, 4, 32'd1);
        checkOutput("burst8_fill", 32'(fill), 0);

        // Burst waits for the fourth sample
        $display("[TB] threshold");
        doFlush();
        clearRec();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h11 + 32'(i));
        wr_en = 1'b0;
        repeat (4) tick();
        checkOutput("thr_valid3", 32'(out_valid), 0);
        checkOutput("thr_fill3", 32'(fill), 3);
        applyStimulus(1'b1, 32'h14);
        wr_en = 1'b0;
        checkOutput("thr_fill4", 32'(fill), 4);
        checkOutput("thr_valid4", 32'(out_valid), 0);
        tick();
        checkOutput("thr_valid5", 32'(out_valid), 0);
        tick();
        checkOutput("thr_first_valid", 32'(out_valid), 1);
        checkOutput("thr_first_data", out_data, 32'h11);
        checkOutput("thr_first_sop", 32'(out_sop), 1);
        repeat (6) tick();
        checkBursts("thr", 4, 4, 32'h11);

        // Overflow when full, then sticky clear
        $display("[TB] overflow");
        doFlush();
        out_ready = 1'b0;
        blk_len = 5'd16;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'h200 + 32'(i));
        checkOutput("ovf_fill16", 32'(fill), 16);
        checkOutput("ovf_wrap_waddr", 32'(ram_waddr), 0);
        checkOutput("ovf_pre", 32'(ovf), 0);
        wr_en = 1'b1;
        wdata = 32'h2FF;
        #1;
        checkOutput("ovf_we_gated", 32'(ram_we), 0);
        tick();
        checkOutput("ovf_set", 32'(ovf), 1);
        checkOutput("ovf_fill_hold", 32'(fill), 16);
        checkOutput("ovf_waddr_hold", 32'(ram_waddr), 0);
        ovf_clr = 1'b1;
        tick();
        checkOutput("ovf_set_beats_clr", 32'(ovf), 1);
        checkOutput("ovf_fill15", 32'(fill), 15);
        checkOutput("ovf_rd_data", out_data, 32'h200);
        checkOutput("ovf_rd_sop", 32'(out_sop), 1);
        wr_en = 1'b0;
        tick();
        checkOutput("ovf_cleared", 32'(ovf), 0);
        ovf_clr = 1'b0;

        // Output held steady while the consumer stalls
        $display("[TB] backpressure");
        doFlush();
        clearRec();
        blk_len = 5'd4;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hA1 + 32'(i));
        wr_en = 1'b0;
        hold_pend = 1'b0;
        for (int c = 0; c < 40 && rec_data.size() < 4; c++) begin
            out_ready = (c % 2) == 0;
            @(negedge clk);
            if (hold_pend) begin
                checkOutput("bp_hold_valid", 32'(out_valid), 1);
                checkOutput("bp_hold_data", out_data, held_data);
                checkOutput("bp_hold_sop", 32'(out_sop), 32'(held_sop));
                checkOutput("bp_hold_eop", 32'(out_eop), 32'(held_eop));
            end
            hold_pend = out_valid && !out_ready;
            held_data = out_data;
            held_sop  = out_sop;
            held_eop  = out_eop;
            tick();
        end
        checkBursts("bp", 4, 4, 32'hA1);

        // Pointer wrap with interleaved writes and reads
        $display("[TB] wrap");
        doFlush();
        clearRec();
        blk_len = 5'd5;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'h100 + 32'(i));
        wr_en = 1'b0;
        repeat (15) tick();
        checkBursts("wrap", 20, 5, 32'h100);
        checkOutput("wrap_fill", 32'(fill), 0);
        checkOutput("wrap_waddr", 32'(ram_waddr), 4);
        checkOutput("wrap_raddr", 32'(ram_raddr), 4);

        // Flush mid-burst
        $display("[TB] flush mid-burst");
        doFlush();
        clearRec();
        blk_len = 5'd4;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hC1 + 32'(i));
        wr_en = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (out_valid && out_data == 32'hC2) found = 1'b1;
            else tick();
        end
        checkOutput("fl_reach_word2", 32'(found), 1);
        doFlush();
        checkOutput("fl_valid", 32'(out_valid), 0);
        checkOutput("fl_fill", 32'(fill), 0);
        checkOutput("fl_raddr", 32'(ram_raddr), 0);
        repeat (6) tick();
        checkOutput("fl_valid_later", 32'(out_valid), 0);
        checkOutput("fl_words", 32'(rec_data.size()), 2);
        for (int i = 0; i < rec_eop.size(); i++) checkOutput("fl_no_eop", 32'(rec_eop[i]), 0);

        // Asynchronous reset mid-burst
        $display("[TB] reset mid-burst");
        clearRec();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hD1 + 32'(i));
        wr_en = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (out_valid && out_data == 32'hD2) found = 1'b1;
            else tick();
        end
        checkOutput("rs_reach_word2", 32'(found), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rs_valid", 32'(out_valid), 0);
        checkOutput("rs_eop", 32'(out_eop), 0);
        checkOutput("rs_data", out_data, 0);
        checkOutput("rs_fill", 32'(fill), 0);
        checkOutput("rs_waddr", 32'(ram_waddr), 0);
        for (int i = 0; i < rec_eop.size(); i++) checkOutput("rs_no_eop", 32'(rec_eop[i]), 0);
        @(negedge clk);
        rst = 1'b0;
        wr_en = 1'b1;
        wdata = 32'hE0;
        #1;
        checkOutput("rs_first_we", 32'(ram_we), 1);
        checkOutput("rs_first_addr", 32'(ram_waddr), 0);
        tick();
        wr_en = 1'b0;
        checkOutput("rs_first_fill", 32'(fill), 1);
        checkOutput("rs_first_mem", mem[0], 32'hE0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buf_reader.md
BUF_READER -- requirements
Module: buf_reader

Interface
REQ-001 Parameter DATA_W, default 32, sample word width.
REQ-002 Parameter ADDR_W, default 10, RAM address width; depth D = 2**ADDR_W.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 wr_en  in  1  writer strobe; one sample offered to buffer this cycle.
REQ-006 flush  in  1  synchronous clear of pointers, fill, FSM, output stage.
REQ-007 blk_len  in  ADDR_W+1  burst length in samples, sampled at burst start.
REQ-008 ovf_clr  in  1  clears sticky overflow flag.
REQ-009 ram_we  out  1  gated write enable to dual-port RAM.
REQ-010 ram_waddr  out  ADDR_W  RAM write address (write pointer).
REQ-011 ram_raddr  out  ADDR_W  RAM read address (read pointer); RAM read is asynchronous.
REQ-012 ram_rdata  in  DATA_W  RAM read data for ram_raddr, same cycle.
REQ-013 out_data  out  DATA_W  registered output sample.
REQ-014 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-015 out_sop / out_eop  out  1 / 1  first / last sample of burst, qualified by out_valid.
REQ-016 fill  out  ADDR_W+1  stored sample count, 0..D.
REQ-017 ovf  out  1  sticky overflow flag.

Function
REQ-018 ram_we SHALL be wr_en AND NOT full AND NOT flush, combinational; full = (fill == D).
REQ-019 Write pointer SHALL increment modulo D on each ram_we; wraps D-1 -> 0.
REQ-020 wr_en while full SHALL drop the sample, leave pointers unchanged, set ovf next cycle.
REQ-021 ovf SHALL clear on ovf_clr; simultaneous overflow and ovf_clr -> ovf stays 1.
REQ-022 FSM states IDLE, BURST; IDLE -> BURST when fill >= L, where L = blk_len, 0 treated as 1, values > D clamped to D; L latched on transition.
REQ-023 In BURST a read fires when NOT out_valid OR out_ready; read loads out_data <= ram_rdata, sets out_valid, advances read pointer modulo D.
REQ-024 out_sop SHALL accompany first read of burst; out_eop the L-th; BURST -> IDLE on the L-th read.
REQ-025 Latency: sample written in cycle N SHALL be readable at earliest cycle N+1; out_valid rises the cycle after the read fires.
REQ-026 out_valid with out_ready low SHALL hold out_data, out_sop, out_eop stable.
REQ-027 out_valid SHALL drop after accepted word when no new read fires that cycle.
REQ-028 fill: +1 on ram_we, -1 on read, unchanged when both coincide; never exceeds D or underflows.
REQ-029 Back-to-back bursts: IDLE re-evaluates fill in the cycle after eop read; no bubble beyond one cycle.
REQ-030 flush SHALL zero pointers, fill, out_valid, sop/eop, return FSM to IDLE next cycle; ovf unaffected; flush mid-burst abandons burst without eop.

Reset
REQ-031 rst SHALL asynchronously force: pointers 0, fill 0, FSM IDLE, out_valid 0, out_sop 0, out_eop 0, out_data 0, ovf 0, latched L = 1.
REQ-032 rst mid-burst SHALL abort without eop; first post-reset write lands at address 0.

Structure
REQ-033 Package buf_pkg SHALL hold FSM state enum and helper constants (depth computation, clamp of blk_len).
REQ-034 Storage array SHALL be external (team dual-port RAM); block contains no memory.
REQ-035 Output register/handshake stage SHALL be sub-module buf_oreg.

Verification (ADDR_W=4, D=16)
REQ-036 Write 8 samples 1..8, blk_len=4, out_ready=1 -> two bursts 1..4, 5..8; sop on 1,5; eop on 4,8; fill ends 0.
REQ-037 Write 3 samples, blk_len=4 -> out_valid stays 0; 4th write -> burst starts next cycle.
REQ-038 Write 17 samples with no reads -> fill=16, 17th dropped, ovf=1; ovf_clr -> ovf=0.
REQ-039 blk_len=4, out_ready toggling 1010... -> 4 words in order, each held stable while out_ready=0.
REQ-040 Pointer wrap: 20 writes/20 reads interleaved, blk_len=5 -> data order intact across 15 -> 0.
REQ-041 Assert flush after 2nd word of burst -> out_valid 0 next cycle, fill 0, no eop; rst mid-burst same result asynchronously.
